// File: rtl/uart_pkg.sv
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared types and constants for the buffered UART receiver.
//                Defines the receive FSM state encoding, the data-bit count
//                and default bit-timing values for a 100 MHz system clock.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    // Default bit timing for a 100 MHz clock
    localparam int UART_CLKS_PER_BIT_100M_10K   = 10000;
    localparam int UART_DIV_WIDTH_100M_10K      = 14;
    localparam int UART_CLKS_PER_BIT_100M_115K2 = 868;
    localparam int UART_DIV_WIDTH_100M_115K2    = 10;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_IDLE = 3'd5
    } rx_state_t;

endpackage

`default_nettype wire

// File: rtl/rx_byte_fifo.sv
// ============================================================================
//  Module      : rx_byte_fifo
//  Description : Single-clock synchronous byte FIFO, 2**DEPTH_LOG2 entries.
//                Head is read combinationally; a write into a full FIFO is
//                accepted only when a pop happens in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rx_byte_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                      Clk_100M,
    input  logic                      Reset,
    input  logic                      wr_en,
    input  logic [UART_DATA_BITS-1:0] wr_data,
    input  logic                      rd_en,
    output logic [UART_DATA_BITS-1:0] rd_data,
    output logic [DEPTH_LOG2:0]       count,
    output logic                      full,
    output logic                      empty
);

    localparam int c_DEPTH = 2 ** DEPTH_LOG2;

    logic [UART_DATA_BITS-1:0] r_mem [c_DEPTH];
    logic [DEPTH_LOG2-1:0]     r_wrPtr;
    logic [DEPTH_LOG2-1:0]     r_rdPtr;
    logic [DEPTH_LOG2:0]       r_count;
    logic                      w_doRead;
    logic                      w_doWrite;

    assign empty     = (r_count == '0);
    assign full      = (r_count == (DEPTH_LOG2 + 1)'(c_DEPTH));
    assign w_doRead  = rd_en && !empty;
    // A full FIFO frees a slot in the same cycle it is popped
    assign w_doWrite = wr_en && (!full || w_doRead);
    assign rd_data   = r_mem[r_rdPtr];
    assign count     = r_count;

    // Storage array; cleared on reset so the head reads 0 when empty
    always_ff @(posedge Clk_100M or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_doWrite) begin
            r_mem[r_wrPtr] <= wr_data;
        end
    end

    // Pointers wrap modulo the depth; occupancy tracks write minus read
    always_ff @(posedge Clk_100M or negedge Reset) begin
        if (!Reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doWrite) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_doRead) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_doWrite, w_doRead})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_rx_buffered.sv
// ============================================================================
//  Module      : uart_rx_buffered
//  Description : UART receiver with byte FIFO and four-phase Rx_Ready/Rx_Ack
//                output handshake. Frames are sampled at mid-bit.
//                Build option: define UART_RX_PARITY_EN for 8E1 frames
//                (default build receives 8N1).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_buffered
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10000,
    parameter int DIV_WIDTH    = 14,
    parameter int DEPTH_LOG2   = 3
) (
    input  logic                      Clk_100M,
    input  logic                      Reset,
    input  logic                      Rx,
    input  logic                      Rx_Ack,
    output logic [UART_DATA_BITS-1:0] Rx_Data,
    output logic                      Rx_Ready,
    output logic [DEPTH_LOG2:0]       Rx_Count,
    output logic                      Frame_Err,
    output logic                      Overflow
);

    localparam logic [DIV_WIDTH-1:0] c_HALF_BIT_LAST = DIV_WIDTH'(CLKS_PER_BIT / 2 - 1);
    localparam logic [DIV_WIDTH-1:0] c_FULL_BIT_LAST = DIV_WIDTH'(CLKS_PER_BIT - 1);
    localparam logic [2:0]           c_LAST_BIT_IDX  = 3'(UART_DATA_BITS - 1);

    logic                      r_rxMeta;
    logic                      r_rxSync;
    rx_state_t                 r_state;
    rx_state_t                 w_stateNext;
    logic [DIV_WIDTH-1:0]      r_bitCnt;
    logic [DIV_WIDTH-1:0]      w_bitCntNext;
    logic [2:0]                r_bitIdx;
    logic [2:0]                w_bitIdxNext;
    logic [UART_DATA_BITS-1:0] r_shift;
    logic [UART_DATA_BITS-1:0] w_shiftNext;
    logic                      w_parityOk;
    logic                      w_byteDone;
    logic                      w_frameErr;
    logic                      r_frameErr;
    logic                      r_ready;
    logic                      r_overflow;
    logic                      w_pop;
    logic                      w_full;
    logic                      w_empty;

`ifdef UART_RX_PARITY_EN
    logic r_parityBit;
    logic w_parityBitNext;

    // Data plus parity must carry an even number of ones
    assign w_parityOk = ~(^{r_shift, r_parityBit});
`else
    assign w_parityOk = 1'b1;
`endif

    // Two-flop synchroniser; idles high so reset does not look like a start bit
    always_ff @(posedge Clk_100M or negedge Reset) begin
        if (!Reset) begin
            r_rxMeta <= 1'b1;
            r_rxSync <= 1'b1;
        end else begin
            r_rxMeta <= Rx;
            r_rxSync <= r_rxMeta;
        end
    end

    // Receive FSM state and datapath registers
    always_ff @(posedge Clk_100M or negedge Reset) begin
        if (!Reset) begin
            r_state    <= IDLE;
            r_bitCnt   <= '0;
            r_bitIdx   <= '0;
            r_shift    <= '0;
            r_frameErr <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parityBit <= 1'b0;
`endif
        end else begin
            r_state    <= w_stateNext;
            r_bitCnt   <= w_bitCntNext;
            r_bitIdx   <= w_bitIdxNext;
            r_shift    <= w_shiftNext;
            r_frameErr <= w_frameErr;
`ifdef UART_RX_PARITY_EN
            r_parityBit <= w_parityBitNext;
`endif
        end
    end

    // Next-state, bit timing and frame accept/reject decisions
    always_comb begin
        w_stateNext  = r_state;
        w_bitCntNext = r_bitCnt + 1'b1;
        w_bitIdxNext = r_bitIdx;
        w_shiftNext  = r_shift;
        w_byteDone   = 1'b0;
        w_frameErr   = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_parityBitNext = r_parityBit;
`endif
        case (r_state)
            IDLE: begin
                w_bitCntNext = '0;
                if (!r_rxSync) begin
                    w_stateNext = START;
                end
            end
            START: begin
                // Re-check the line at mid start bit to reject glitches
                if (r_bitCnt == c_HALF_BIT_LAST) begin
                    w_bitCntNext = '0;
                    w_bitIdxNext = '0;
                    w_stateNext  = r_rxSync ? IDLE : DATA;
                end
            end
            DATA: begin
                if (r_bitCnt == c_FULL_BIT_LAST) begin
                    w_bitCntNext = '0;
                    w_shiftNext  = {r_rxSync, r_shift[UART_DATA_BITS-1:1]};
                    w_bitIdxNext = r_bitIdx + 1'b1;
                    if (r_bitIdx == c_LAST_BIT_IDX) begin
`ifdef UART_RX_PARITY_EN
                        w_stateNext = PARITY;
`else
                        w_stateNext = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (r_bitCnt == c_FULL_BIT_LAST) begin
                    w_bitCntNext    = '0;
                    w_parityBitNext = r_rxSync;
                    w_stateNext     = STOP;
                end
            end
`endif
            STOP: begin
                if (r_bitCnt == c_FULL_BIT_LAST) begin
                    w_bitCntNext = '0;
                    if (r_rxSync && w_parityOk) begin
                        w_byteDone  = 1'b1;
                        w_stateNext = IDLE;
                    end else begin
                        w_frameErr  = 1'b1;
                        w_stateNext = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                // A held break must not be mistaken for a new start bit
                w_bitCntNext = '0;
                if (r_rxSync) begin
                    w_stateNext = IDLE;
                end
            end
            default: begin
                w_bitCntNext = '0;
                w_stateNext  = IDLE;
            end
        endcase
    end

    rx_byte_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .Clk_100M (Clk_100M),
        .Reset    (Reset),
        .wr_en    (w_byteDone),
        .wr_data  (r_shift),
        .rd_en    (w_pop),
        .rd_data  (Rx_Data),
        .count    (Rx_Count),
        .full     (w_full),
        .empty    (w_empty)
    );

    assign w_pop = r_ready && Rx_Ack;

    // Four-phase handshake: raise on data with Ack low, drop on Ack
    always_ff @(posedge Clk_100M or negedge Reset) begin
        if (!Reset) begin
            r_ready <= 1'b0;
        end else if (r_ready) begin
            if (Rx_Ack) begin
                r_ready <= 1'b0;
            end
        end else if (!Rx_Ack && !w_empty) begin
            r_ready <= 1'b1;
        end
    end

    // Sticky overflow when a completed byte finds no free slot
    always_ff @(posedge Clk_100M or negedge Reset) begin
        if (!Reset) begin
            r_overflow <= 1'b0;
        end else if (w_byteDone && w_full && !w_pop) begin
            r_overflow <= 1'b1;
        end
    end

    assign Rx_Ready  = r_ready;
    assign Frame_Err = r_frameErr;
    assign Overflow  = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_buffered.sv
// ============================================================================
//  Module      : tb_uart_rx_buffered
//  Description : Directed self-checking bench for uart_rx_buffered with
//                CLKS_PER_BIT=16. Honours UART_RX_PARITY_EN for 8E1 frames.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_buffered;

    localparam int CLKS       = 16;
    localparam int DEPTH_LOG2 = 3;
`ifdef UART_RX_PARITY_EN
    localparam int c_WRITE_LAT = 2 + CLKS / 2 + 9 * CLKS + CLKS;
`else
    localparam int c_WRITE_LAT = 2 + CLKS / 2 + 9 * CLKS;
`endif

    logic                  Clk_100M;
    logic                  Reset;
    logic                  Rx;
    logic                  Rx_Ack;
    logic [7:0]            Rx_Data;
    logic                  Rx_Ready;
    logic [DEPTH_LOG2:0]   Rx_Count;
    logic                  Frame_Err;
    logic                  Overflow;

    int nCompared   = 0;
    int nMismatched = 0;
    int cyc         = 0;
    int lastStart   = 0;
    int writeCyc    = 0;
    int readyRise   = 0;
    int feCount     = 0;
    int feRun       = 0;
    int feMaxRun    = 0;
    int feBefore    = 0;
    int readySeen   = 0;
    logic [DEPTH_LOG2:0] prevCount = '0;
    logic                prevReady = 1'b0;

    uart_rx_buffered #(
        .CLKS_PER_BIT (CLKS),
        .DIV_WIDTH    (4),
        .DEPTH_LOG2   (DEPTH_LOG2)
    ) dut (
        .Clk_100M  (Clk_100M),
        .Reset     (Reset),
        .Rx        (Rx),
        .Rx_Ack    (Rx_Ack),
        .Rx_Data   (Rx_Data),
        .Rx_Ready  (Rx_Ready),
        .Rx_Count  (Rx_Count),
        .Frame_Err (Frame_Err),
        .Overflow  (Overflow)
    );

    initial begin
        Clk_100M = 1'b0;
        forever #5 Clk_100M = ~Clk_100M;
    end

    // Cycle counter: number of rising edges so far
    always @(posedge Clk_100M) cyc <= cyc + 1;

    // Event monitor: Frame_Err pulses, FIFO write and Rx_Ready rise times
    always @(negedge Clk_100M) begin
        if (Frame_Err) begin
            feCount++;
            feRun++;
            if (feRun > feMaxRun) feMaxRun = feRun;
        end else begin
            feRun = 0;
        end
        if (Rx_Count > prevCount) writeCyc = cyc;
        if (Rx_Ready && !prevReady) readyRise = cyc;
        prevCount = Rx_Count;
        prevReady = Rx_Ready;
    end

    task automatic checkValue(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Drives one frame starting at a falling clock edge; leaves Rx at the stop level
    task automatic sendByte(input logic [7:0] b, input logic stopBit, input logic parBit);
        lastStart = cyc + 1;
        Rx = 1'b0;
        repeat (CLKS) @(negedge Clk_100M);
        for (int i = 0; i < 8; i++) begin
            Rx = b[i];
            repeat (CLKS) @(negedge Clk_100M);
        end
`ifdef UART_RX_PARITY_EN
        Rx = parBit;
        repeat (CLKS) @(negedge Clk_100M);
`else
        if (parBit === 1'bx) Rx = 1'b1;
`endif
        Rx = stopBit;
        repeat (CLKS) @(negedge Clk_100M);
    endtask

    task automatic sendGood(input logic [7:0] b);
        sendByte(b, 1'b1, ^b);
    endtask

    task automatic waitReady(input logic lvl, input string tag);
        int n = 0;
        while (Rx_Ready !== lvl && n < 2000) begin
            @(negedge Clk_100M);
            n++;
        end
        if (Rx_Ready !== lvl) checkValue({tag, "_timeout"}, 32'(Rx_Ready), 32'(lvl));
    endtask

    task automatic popByte(input logic [7:0] exp, input string tag);
        waitReady(1'b1, tag);
        checkValue(tag, 32'(Rx_Data), 32'(exp));
        Rx_Ack = 1'b1;
        @(negedge Clk_100M);
        waitReady(1'b0, tag);
        Rx_Ack = 1'b0;
        @(negedge Clk_100M);
    endtask

    initial begin
        Reset  = 1'b0;
        Rx     = 1'b1;
        Rx_Ack = 1'b0;
        repeat (5) @(negedge Clk_100M);
        checkValue("rst_ready", 32'(Rx_Ready), 0);
        Reset = 1'b1;
        @(negedge Clk_100M);
        checkValue("rst_data",     32'(Rx_Data),   0);
        checkValue("rst_count",    32'(Rx_Count),  0);
        checkValue("rst_frameerr", 32'(Frame_Err), 0);
        checkValue("rst_overflow", 32'(Overflow),  0);
        repeat (1000) begin
            @(negedge Clk_100M);
            if (Rx_Ready) readySeen++;
        end
        checkValue("idle_no_ready", 32'(readySeen), 0);

        // Single frame and four-phase acknowledge
        sendGood(8'h41);
        waitReady(1'b1, "f41_ready");
        checkValue("f41_data", 32'(Rx_Data), 32'h41);
        @(negedge Clk_100M);
        checkValue("f41_start_to_write", 32'(writeCyc - lastStart), 32'(c_WRITE_LAT));
        checkValue("f41_write_to_ready", 32'(readyRise - writeCyc), 1);
        Rx_Ack = 1'b1;
        @(negedge Clk_100M);
        checkValue("f41_ack_to_ready_low", 32'(Rx_Ready), 0);
        checkValue("f41_count_after_pop",  32'(Rx_Count), 0);
        Rx_Ack = 1'b0;
        @(negedge Clk_100M);
        checkValue("no_overflow_yet", 32'(Overflow), 0);

        // Ten back-to-back frames into an eight-entry FIFO
        for (int i = 0; i < 10; i++) sendGood(8'(8'h30 + i));
        repeat (20) @(negedge Clk_100M);
        checkValue("burst_count",    32'(Rx_Count), 8);
        checkValue("burst_overflow", 32'(Overflow), 1);
        for (int i = 0; i < 8; i++) popByte(8'(8'h30 + i), "burst_drain");
        checkValue("burst_empty", 32'(Rx_Count), 0);

        // Short low glitch is ignored silently
        feBefore = feCount;
        Rx = 1'b0;
        repeat (6) @(negedge Clk_100M);
        Rx = 1'b1;
        repeat (40) @(negedge Clk_100M);
        checkValue("glitch_no_err",  32'(feCount - feBefore), 0);
        checkValue("glitch_no_byte", 32'(Rx_Count), 0);
        sendGood(8'h55);
        popByte(8'h55, "after_glitch");

        // Zero stop bit followed by a held break
        feBefore = feCount;
        feMaxRun = 0;
        sendByte(8'h5A, 1'b0, 1'b0);
        repeat (200) @(negedge Clk_100M);
        checkValue("break_one_err",   32'(feCount - feBefore), 1);
        checkValue("break_err_width", 32'(feMaxRun), 1);
        checkValue("break_no_byte",   32'(Rx_Count), 0);
        Rx = 1'b1;
        repeat (40) @(negedge Clk_100M);
        sendGood(8'h66);
        popByte(8'h66, "after_break");

        // Write lands on the same edge as a pop of a full FIFO
        for (int i = 0; i < 8; i++) sendGood(8'(8'h70 + i));
        waitReady(1'b1, "full_ready");
        checkValue("full_before", 32'(Rx_Count), 8);
        fork
            sendGood(8'h78);
            begin
                repeat (c_WRITE_LAT) @(negedge Clk_100M);
                Rx_Ack = 1'b1;
                @(negedge Clk_100M);
                checkValue("wrpop_count", 32'(Rx_Count), 8);
                checkValue("wrpop_ready", 32'(Rx_Ready), 0);
                Rx_Ack = 1'b0;
            end
        join
        for (int i = 1; i < 9; i++) popByte(8'(8'h70 + i), "wrpop_drain");
        checkValue("wrpop_empty", 32'(Rx_Count), 0);

`ifdef UART_RX_PARITY_EN
        sendByte(8'h41, 1'b1, 1'b0);
        popByte(8'h41, "par_good");
        feBefore = feCount;
        sendByte(8'h41, 1'b1, 1'b1);
        repeat (20) @(negedge Clk_100M);
        checkValue("par_bad_err",     32'(feCount - feBefore), 1);
        checkValue("par_bad_no_byte", 32'(Rx_Count), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

`default_nettype wire
